cic_dec_sched: RTL and testbench
================================

Name: cic_dec_sched

Overview:
- Sequencer and time-division arbiter for the shared accumulate-and-dump decimation datapath. One adder and accumulator bank serve NCH interleaved PCM channels.
- Derives the input-sample cadence from mclk: 128 mclk per 352.8 kHz input sample at 45.1584 MHz.
- Issues per-channel accumulate/dump commands and selects the runtime decimation ratio.
- Presents decimated output frames to downstream logic with a valid/ready handshake.

Parameters:
- CYC_PER_IN, 128, mclk cycles per input sample period; must be >= NCH.
- NCH, 2, number of channels sharing the datapath.
- CHW, 1, width of the channel index; equals clog2(NCH), minimum 1.

Ports:
- mclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; low aborts and holds the block idle.
- ratio_log2  in  2  requested decimation ratio R = 2**ratio_log2 (1, 2, 4 or 8).
- in_strobe  out  1  one-cycle pulse at the end of each input sample period; upstream advances pcm_in.
- op_valid  out  1  datapath command valid this cycle.
- op_ch  out  CHW  channel index for the command.
- op_first  out  1  datapath uses sum = pcm_in; when low, sum = acc[op_ch] + pcm_in.
- op_last  out  1  high: out[op_ch] <= sum; low: acc[op_ch] <= sum.
- ratio_active  out  2  ratio currently in effect.
- out_valid  out  1  a decimated frame (all NCH channels) is available.
- out_ready  in  1  downstream accepts the frame.
- overrun  out  1  sticky: a frame completed while the previous one was unaccepted.

Behaviour:
- Reset, or en low, in any cycle, synchronously produces the following on the next edge:
  - cyc=0, smp=0.
  - All outputs 0, except ratio_active, which reset sets to 0 and en low leaves unchanged.
  - Any in-progress frame is discarded; no partial dump is ever issued.
- Counters:
  - cyc counts 0..CYC_PER_IN-1 and wraps while en=1.
  - smp counts 0..R-1 and advances when cyc wraps.
  - in_strobe = en & (cyc==CYC_PER_IN-1).
- Command slots: for k in 0..NCH-1, at cyc==CYC_PER_IN-NCH+k:
  - op_valid=1, op_ch=k.
  - op_first=(smp==0), op_last=(smp==R-1); both are 1 when R=1.
  - All outputs are registered and decoded from the current counter state.
- Ratio:
  - ratio_log2 is sampled into ratio_active when en=1 and (cyc,smp)=(0,0). This is the first cycle of every frame, including the first cycle after en rises.
  - Mid-frame changes of ratio_log2 are ignored until the next frame boundary.
- FSM:
  - IDLE -> RUN when en=1; RUN -> IDLE when en=0.
  - In IDLE, counters hold at 0.
- Output handshake:
  - out_valid rises the cycle after the command with op_last=1 and op_ch=NCH-1.
  - out_valid clears on out_valid & out_ready.
  - Completion in the same cycle as acceptance: out_valid stays 1 and overrun is not set.
  - Completion while out_valid=1 and out_ready=0: overrun <= 1, out_valid stays 1, and the datapath overwrites the output registers.
  - overrun clears only on reset or en low.
- Latency: first out_valid occurs R*CYC_PER_IN cycles after the first RUN cycle.

Decomposition:
- Shared package cic_pkg holds:
  - localparam CYC_PER_IN_DEF=128;
  - localparam NCH_DEF=2;
  - the function ratio_from_log2.
- One natural sub-module, cic_phase_cnt: the cyc/smp counter pair with the frame-boundary ratio latch. The handshake and command decode stay in the top level.

Test Plan:
- Reset held 5 cycles, then en=1 at cycle 0 with ratio_log2=3 -> check the following:
  - op (ch0) at cycles 126, 254, …, 1022.
  - op (ch1) at cycles 127, …, 1023.
  - op_first only at 126/127.
  - op_last only at 1022/1023.
  - out_valid=1 at 1024.
  - in_strobe at 127, 255, ….
- ratio_log2=0 -> every slot has op_first=op_last=1; out_valid at cycle 128 and every 128 cycles while out_ready=1.
- ratio_log2 changed 3->1 at cycle 300 -> frame 1 still dumps at 1022/1023; ratio_active=1 from cycle 1024; next dump at 1278/1279.
- out_ready=0 with R=1 -> out_valid held from 128; overrun=1 at cycle 256. Then out_ready=1 exactly at cycle 255 on a fresh run -> no overrun.
- en dropped at cycle 600 (R=8), raised at 700 -> no op_last in the aborted frame; outputs 0 at 601; next first op at 826, next out_valid at 1724.
- reset asserted mid-frame at cycle 500 -> all outputs 0 at 501; restart timing identical to the first scenario.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation scheduler: default geometry,
// FSM state encoding and ratio decode.
package cic_pkg;

  localparam int CYC_PER_IN_DEF = 128;
  localparam int NCH_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] ratio_from_log2(input logic [1:0] l2);
    return 4'd1 << l2;
  endfunction

endpackage

// File: rtl/cic_phase_cnt.sv
// Input-sample cycle counter and per-frame sample counter, with the decimation
// ratio latched on the first cycle of each frame.
module cic_phase_cnt
  import cic_pkg::*;
#(
  parameter int CYC_PER_IN = CYC_PER_IN_DEF,
  parameter int CYCW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adv,
  input  logic [1:0]      ratio_log2,
  output logic [CYCW-1:0] cyc_next,
  output logic [2:0]      smp_next,
  output logic [1:0]      ratio_next,
  output logic [1:0]      ratio_active
);

  logic [CYCW-1:0] cyc;
  logic [2:0]      smp;
  logic            boundary;
  logic            cyc_wrap;
  logic [3:0]      r;

  // ratio_next is the ratio governing the state being entered, so decode of
  // the first frame cycle already sees a freshly requested ratio.
  always_comb begin
    boundary   = adv && (cyc == '0) && (smp == '0);
    ratio_next = boundary ? ratio_log2 : ratio_active;
    r          = ratio_from_log2(ratio_next);
    cyc_wrap   = (cyc == CYCW'(CYC_PER_IN - 1));
    cyc_next   = '0;
    smp_next   = '0;
    if (adv) begin
      cyc_next = cyc_wrap ? '0 : cyc + CYCW'(1);
      if (cyc_wrap)
        smp_next = ({1'b0, smp} == (r - 4'd1)) ? 3'd0 : smp + 3'd1;
      else
        smp_next = smp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc          <= '0;
      smp          <= '0;
      ratio_active <= '0;
    end else begin
      cyc          <= cyc_next;
      smp          <= smp_next;
      ratio_active <= ratio_next;
    end
  end

endmodule

// File: rtl/cic_dec_sched.sv
// Time-division sequencer for the shared accumulate-and-dump decimator:
// per-channel command slots, runtime ratio, and output frame handshake.
module cic_dec_sched
  import cic_pkg::*;
#(
  parameter int CYC_PER_IN = CYC_PER_IN_DEF,
  parameter int NCH = NCH_DEF,
  parameter int CHW = 1
) (
  input  logic           mclk,
  input  logic           reset,
  input  logic           en,
  input  logic [1:0]     ratio_log2,
  output logic           in_strobe,
  output logic           op_valid,
  output logic [CHW-1:0] op_ch,
  output logic           op_first,
  output logic           op_last,
  output logic [1:0]     ratio_active,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           overrun
);

  localparam int CYCW  = (CYC_PER_IN > 1) ? $clog2(CYC_PER_IN) : 1;
  localparam int SLOT0 = CYC_PER_IN - NCH;

  state_t          state;
  state_t          state_nxt;
  logic            adv;
  logic [CYCW-1:0] cyc_next;
  logic [2:0]      smp_next;
  logic [1:0]      ratio_next;
  logic [3:0]      r_next;
  logic [CYCW-1:0] slot_off;
  logic            slot_next;
  logic            first_next;
  logic            last_next;
  logic            strobe_next;
  logic            done;

  always_ff @(posedge mclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first enabled cycle is still IDLE but already counts as frame cycle 0.
  always_comb begin
    adv = 1'b0;
    case (state)
      IDLE:    adv = en;
      RUN:     adv = en;
      default: adv = 1'b0;
    endcase
  end

  cic_phase_cnt #(
    .CYC_PER_IN(CYC_PER_IN),
    .CYCW      (CYCW)
  ) u_phase (
    .clk         (mclk),
    .reset       (reset),
    .adv         (adv),
    .ratio_log2  (ratio_log2),
    .cyc_next    (cyc_next),
    .smp_next    (smp_next),
    .ratio_next  (ratio_next),
    .ratio_active(ratio_active)
  );

  // Outputs are decoded from the counter state being entered, so the
  // registered command lines up with the cycle whose counter value it names.
  always_comb begin
    r_next      = ratio_from_log2(ratio_next);
    slot_off    = cyc_next - CYCW'(SLOT0);
    slot_next   = adv && (cyc_next >= CYCW'(SLOT0));
    first_next  = slot_next && (smp_next == 3'd0);
    last_next   = slot_next && ({1'b0, smp_next} == (r_next - 4'd1));
    strobe_next = adv && (cyc_next == CYCW'(CYC_PER_IN - 1));
    done        = op_valid && op_last && (op_ch == CHW'(NCH - 1));
  end

  always_ff @(posedge mclk) begin
    if (reset || !en) begin
      in_strobe <= 1'b0;
      op_valid  <= 1'b0;
      op_ch     <= '0;
      op_first  <= 1'b0;
      op_last   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      in_strobe <= strobe_next;
      op_valid  <= slot_next;
      op_ch     <= slot_next ? slot_off[CHW-1:0] : '0;
      op_first  <= first_next;
      op_last   <= last_next;
      // A completing frame wins over acceptance; overrun only if it was unread.
      if (done) begin
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_dec_sched.sv
// Directed bench for cic_dec_sched with per-cycle expected vectors derived
// from the frame timing of each scenario.
module tb_cic_dec_sched;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] ratio_log2 = 2'd0;
  logic       out_ready = 1'b1;
  logic       in_strobe;
  logic       op_valid;
  logic [0:0] op_ch;
  logic       op_first;
  logic       op_last;
  logic [1:0] ratio_active;
  logic       out_valid;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  always #5 mclk = ~mclk;

  cic_dec_sched #(
    .CYC_PER_IN(128),
    .NCH       (2),
    .CHW       (1)
  ) dut (
    .mclk        (mclk),
    .reset       (reset),
    .en          (en),
    .ratio_log2  (ratio_log2),
    .in_strobe   (in_strobe),
    .op_valid    (op_valid),
    .op_ch       (op_ch),
    .op_first    (op_first),
    .op_last     (op_last),
    .ratio_active(ratio_active),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  // {in_strobe, op_valid, op_ch, op_first, op_last, out_valid, overrun}
  // u = cycles since the first enabled cycle, r = ratio, downstream always ready.
  function automatic logic [6:0] exp_vec(input int u, input int r);
    int  m;
    int  f;
    logic ov;
    if (u < 0) return 7'd0;
    m  = u % 128;
    f  = (u / 128) % r;
    ov = (m >= 126);
    return {m == 127, ov, m == 127, ov && (f == 0), ov && (f == r - 1),
            (u > 0) && (u % (128 * r) == 0), 1'b0};
  endfunction

  function automatic logic [6:0] got_vec();
    return {in_strobe, op_valid, op_ch, op_first, op_last, out_valid, overrun};
  endfunction

  task automatic apply_reset(input logic [1:0] rl);
    @(negedge mclk);
    reset = 1'b1;
    en = 1'b0;
    ratio_log2 = rl;
    out_ready = 1'b1;
    repeat (5) @(negedge mclk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    apply_reset(2'd0);
    out_ready = 1'b0;
    en = 1'b1;
    repeat (300) @(negedge mclk);
    apply_reset(2'd2);
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      checks++;
      if (got !== 7'd0) begin
        failures++;
        $display("FAIL reset_outputs t=%0d got=%b exp=%b", t, got, 7'd0);
      end
      checks++;
      if (ratio_active !== 2'd0) begin
        failures++;
        $display("FAIL reset_ratio t=%0d got=%0d exp=0", t, ratio_active);
      end
    end
  endtask

  task automatic test_ratio8();
    logic [6:0] got, exp;
    apply_reset(2'd3);
    for (int t = 0; t <= 1100; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      exp = exp_vec(t, 8);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL r8_seq t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 0 || t == 1 || t == 1024) begin
        checks++;
        if (ratio_active !== ((t == 0) ? 2'd0 : 2'd3)) begin
          failures++;
          $display("FAIL r8_ratio t=%0d got=%0d exp=%0d", t, ratio_active, (t == 0) ? 0 : 3);
        end
      end
      if (t == 0) en = 1'b1;
    end
  endtask

  task automatic test_ratio1();
    logic [6:0] got, exp;
    apply_reset(2'd0);
    for (int t = 0; t <= 400; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      exp = exp_vec(t, 1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL r1_seq t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 0) en = 1'b1;
    end
  endtask

  task automatic test_ratio_change();
    logic [6:0] got, exp;
    apply_reset(2'd3);
    for (int t = 0; t <= 1300; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      exp = (t <= 1024) ? exp_vec(t, 8) : exp_vec(t - 1024, 2);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rchg_seq t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 1023 || t == 1025) begin
        checks++;
        if (ratio_active !== ((t == 1023) ? 2'd3 : 2'd1)) begin
          failures++;
          $display("FAIL rchg_ratio t=%0d got=%0d exp=%0d", t, ratio_active, (t == 1023) ? 3 : 1);
        end
      end
      if (t == 0) en = 1'b1;
      if (t == 300) ratio_log2 = 2'd1;
    end
  endtask

  task automatic test_overrun();
    logic [6:0] got, exp;
    apply_reset(2'd0);
    out_ready = 1'b0;
    for (int t = 0; t <= 300; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      exp = exp_vec(t, 1);
      exp[1] = (t >= 128);
      exp[0] = (t >= 256);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ovr_seq t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 0) en = 1'b1;
    end
    apply_reset(2'd0);
    out_ready = 1'b0;
    for (int t = 0; t <= 300; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      exp = exp_vec(t, 1);
      exp[1] = (t >= 128);
      exp[0] = 1'b0;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL accept_same_cycle t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 0) en = 1'b1;
      out_ready = (t == 255);
    end
  endtask

  task automatic test_en_abort();
    logic [6:0] got, exp;
    apply_reset(2'd3);
    for (int t = 0; t <= 1730; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      if (t <= 600)      exp = exp_vec(t, 8);
      else if (t <= 700) exp = 7'd0;
      else               exp = exp_vec(t - 700, 8);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort_seq t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 650) begin
        checks++;
        if (ratio_active !== 2'd3) begin
          failures++;
          $display("FAIL abort_ratio_hold t=%0d got=%0d exp=3", t, ratio_active);
        end
      end
      if (t == 0)   en = 1'b1;
      if (t == 600) en = 1'b0;
      if (t == 700) en = 1'b1;
    end
  endtask

  task automatic test_reset_midframe();
    logic [6:0] got, exp;
    apply_reset(2'd3);
    for (int t = 0; t <= 1530; t++) begin
      if (t > 0) @(negedge mclk);
      got = got_vec();
      exp = (t <= 500) ? exp_vec(t, 8) : exp_vec(t - 501, 8);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL midrst_seq t=%0d got=%b exp=%b", t, got, exp);
      end
      if (t == 501 || t == 502) begin
        checks++;
        if (ratio_active !== ((t == 501) ? 2'd0 : 2'd3)) begin
          failures++;
          $display("FAIL midrst_ratio t=%0d got=%0d exp=%0d", t, ratio_active, (t == 501) ? 0 : 3);
        end
      end
      if (t == 0)   en = 1'b1;
      if (t == 500) reset = 1'b1;
      if (t == 501) reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_ratio8();
    test_ratio1();
    test_ratio_change();
    test_overrun();
    test_en_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
